// File: rtl/tx_lane_packer.sv
// Byte-to-lane packer: accepts one byte per cycle and emits LANES-wide words with a lane-valid mask.
// A completed word is held in the assembly register while the output register is still occupied.
module tx_lane_packer #(
   parameter int LANES  = 8,
   parameter int BYTE_W = 8
) (
   input  logic                      txclk,
   input  logic                      reset,
   input  logic [BYTE_W-1:0]         in_data,
   input  logic                      in_valid,
   input  logic                      in_eof,
   output logic                      in_ready,
   output logic [LANES*BYTE_W-1:0]   out_data,
   output logic [LANES-1:0]          out_mask,
   output logic                      out_eof,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int PTR_W  = $clog2(LANES);
   localparam int WORD_W = LANES * BYTE_W;

   logic [PTR_W-1:0]  ptr_reg;
   logic [WORD_W-1:0] asm_data_reg;
   logic [LANES-1:0]  asm_mask_reg;
   logic              asm_eof_reg;
   logic              full_reg;

   logic [WORD_W-1:0] word_data;
   logic [LANES-1:0]  word_mask;
   logic [LANES-1:0]  lane_sel;
   logic              word_eof;
   logic              accept;
   logic              last_lane;
   logic              complete;
   logic              out_free;
   logic              transfer;

   assign in_ready  = ~full_reg;
   assign accept    = in_valid & ~full_reg;
   assign last_lane = (ptr_reg == PTR_W'(LANES - 1));
   // A held word counts as complete every cycle until it can move out.
   assign complete  = full_reg | (accept & (last_lane | in_eof));
   assign out_free  = ~out_valid | out_ready;
   assign transfer  = complete & out_free;
   assign word_eof  = accept ? in_eof : asm_eof_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_sel[gi] = accept && (ptr_reg == PTR_W'(gi));
         assign word_data[gi*BYTE_W +: BYTE_W] =
            lane_sel[gi] ? in_data : asm_data_reg[gi*BYTE_W +: BYTE_W];
         assign word_mask[gi] = lane_sel[gi] | asm_mask_reg[gi];
      end
   endgenerate

   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         ptr_reg      <= '0;
         asm_data_reg <= '0;
         asm_mask_reg <= '0;
         asm_eof_reg  <= 1'b0;
         full_reg     <= 1'b0;
      end else if (transfer) begin
         ptr_reg      <= '0;
         asm_data_reg <= '0;
         asm_mask_reg <= '0;
         asm_eof_reg  <= 1'b0;
         full_reg     <= 1'b0;
      end else if (complete) begin
         ptr_reg      <= '0;
         asm_data_reg <= word_data;
         asm_mask_reg <= word_mask;
         asm_eof_reg  <= word_eof;
         full_reg     <= 1'b1;
      end else if (accept) begin
         ptr_reg      <= ptr_reg + PTR_W'(1);
         asm_data_reg <= word_data;
         asm_mask_reg <= word_mask;
         asm_eof_reg  <= word_eof;
      end
   end

   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_mask  <= '0;
         out_eof   <= 1'b0;
         out_valid <= 1'b0;
      end else if (transfer) begin
         out_data  <= word_data;
         out_mask  <= word_mask;
         out_eof   <= word_eof;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tx_lane_packer.sv
// Bench for tx_lane_packer: table-driven frames, hand sequences for backpressure and reset,
// and a randomized run against a queue-based word model.
module tb_tx_lane_packer;

   logic        txclk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_eof = 1'b0;
   logic        in_ready;
   logic [63:0] out_data;
   logic [7:0]  out_mask;
   logic        out_eof;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   tx_lane_packer #(.LANES(8), .BYTE_W(8)) dut (
      .txclk(txclk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_eof(in_eof), .in_ready(in_ready),
      .out_data(out_data), .out_mask(out_mask), .out_eof(out_eof),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 txclk = ~txclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic [7:0] d, input logic e);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_eof = e;
      while (!in_ready && t < 50) begin
         @(negedge txclk);
         t++;
      end
      if (!in_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: in_ready stayed 0 for byte %h", d);
      end
      @(negedge txclk);
      in_valid = 1'b0; in_eof = 1'b0;
   endtask

   task automatic chk_word(input string name, input logic [63:0] d, input logic [7:0] m, input logic e);
      chk({name, "_valid"}, {63'b0, out_valid}, 64'd1);
      chk({name, "_data"},  out_data, d);
      chk({name, "_mask"},  {56'b0, out_mask}, {56'b0, m});
      chk({name, "_eof"},   {63'b0, out_eof}, {63'b0, e});
   endtask

   typedef struct {
      logic [63:0] din;
      int          n;
      logic        eof;
      logic [63:0] exp_data;
      logic [7:0]  exp_mask;
      logic        exp_eof;
   } frame_t;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  m;
      logic        e;
   } word_t;

   frame_t vec [6];
   word_t  q [$];
   logic [7:0] cur [$];

   initial begin
      word_t w;
      logic hold;
      logic [63:0] pd;
      logic [7:0]  pm;
      logic        pe;

      vec[0] = '{64'h0807060504030201, 8, 1'b0, 64'h0807060504030201, 8'hFF, 1'b0};
      vec[1] = '{64'h0000000000CCBBAA, 3, 1'b1, 64'h0000000000CCBBAA, 8'h07, 1'b1};
      vec[2] = '{64'h0000000000000011, 1, 1'b1, 64'h0000000000000011, 8'h01, 1'b1};
      vec[3] = '{64'h000000000000005A, 1, 1'b1, 64'h000000000000005A, 8'h01, 1'b1};
      vec[4] = '{64'h8877665544332211, 8, 1'b1, 64'h8877665544332211, 8'hFF, 1'b1};
      vec[5] = '{64'h000000F0E0D0C0B0, 5, 1'b1, 64'h000000F0E0D0C0B0, 8'h1F, 1'b1};

      // Reset state
      @(negedge txclk);
      chk("rst_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_mask", {56'b0, out_mask}, 64'd0);
      chk("rst_eof", {63'b0, out_eof}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      reset = 1'b0;
      @(negedge txclk);

      // Table-driven single-word frames, downstream always ready
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vec[i].n; j++)
            send(vec[i].din[j*8 +: 8], vec[i].eof && (j == vec[i].n - 1));
         chk_word($sformatf("frame%0d", i), vec[i].exp_data, vec[i].exp_mask, vec[i].exp_eof);
         @(negedge txclk);
         chk($sformatf("frame%0d_one_word", i), {63'b0, out_valid}, 64'd0);
      end

      // Backpressure: 16 bytes with out_ready low
      out_ready = 1'b0;
      for (int j = 0; j < 16; j++) send(8'(j), 1'b0);
      chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      chk_word("bp_first", 64'h0706050403020100, 8'hFF, 1'b0);
      repeat (2) @(negedge txclk);
      chk_word("bp_first_stable", 64'h0706050403020100, 8'hFF, 1'b0);
      out_ready = 1'b1;
      @(negedge txclk);
      chk_word("bp_second", 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
      chk("bp_in_ready_back", {63'b0, in_ready}, 64'd1);
      @(negedge txclk);
      chk("bp_drained", {63'b0, out_valid}, 64'd0);

      // Reset mid-word after 5 bytes
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) send(8'h30 + 8'(j), 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("rst5_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst5_valid", {63'b0, out_valid}, 64'd0);
      @(negedge txclk);
      reset = 1'b0;
      out_ready = 1'b1;
      send(8'h77, 1'b1);
      chk_word("rst5_after", 64'h77, 8'h01, 1'b1);
      @(negedge txclk);

      // Reset while a word is held
      out_ready = 1'b0;
      for (int j = 0; j < 16; j++) send(8'h40 + 8'(j), 1'b0);
      chk("hold_in_ready_low", {63'b0, in_ready}, 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("rsth_valid", {63'b0, out_valid}, 64'd0);
      chk("rsth_mask", {56'b0, out_mask}, 64'd0);
      chk("rsth_data", out_data, 64'd0);
      chk("rsth_in_ready", {63'b0, in_ready}, 64'd1);
      @(negedge txclk);
      reset = 1'b0;
      out_ready = 1'b1;
      send(8'h77, 1'b1);
      chk_word("rsth_after", 64'h77, 8'h01, 1'b1);
      @(negedge txclk);
      chk("rsth_one_word", {63'b0, out_valid}, 64'd0);

      // Randomized run against the word-queue model
      hold = 1'b0; pd = '0; pm = '0; pe = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge txclk);
         if (hold) begin
            if (!out_valid || out_data !== pd || out_mask !== pm || out_eof !== pe)
               chk_word($sformatf("stable_c%0d", c), pd, pm, pe);
            else
               n_vec++;
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_eof    = ($urandom_range(0, 5) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid) begin
            if ((out_mask & (out_mask + 8'd1)) != 8'd0)
               chk($sformatf("contig_c%0d", c), {56'b0, out_mask}, 64'd0);
            else
               n_vec++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL rand_extra_word c%0d: got %h expected no word", c, out_data);
            end else begin
               w = q.pop_front();
               n_vec++;
               if (out_data !== w.d || out_mask !== w.m || out_eof !== w.e) begin
                  n_err++;
                  $display("FAIL rand_word c%0d: got %h/%h/%b expected %h/%h/%b",
                           c, out_data, out_mask, out_eof, w.d, w.m, w.e);
               end
            end
         end
         if (in_valid && in_ready) begin
            cur.push_back(in_data);
            if (cur.size() == 8 || in_eof) begin
               w.d = '0;
               for (int k = 0; k < cur.size(); k++) w.d[k*8 +: 8] = cur[k];
               w.m = 8'((1 << cur.size()) - 1);
               w.e = in_eof;
               q.push_back(w);
               cur.delete();
            end
         end
         hold = out_valid && !out_ready;
         pd = out_data; pm = out_mask; pe = out_eof;
      end

      // Drain remaining complete words
      @(negedge txclk);
      in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL drain_extra_word: got %h expected no word", out_data);
            end else begin
               w = q.pop_front();
               chk_word("drain", w.d, w.m, w.e);
            end
         end
         @(negedge txclk);
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
